// File: rtl/medidor_desempenho_mem_tester_pkg.sv
// Shared types, defaults and LFSR helpers for the program-memory tester.
package medidor_desempenho_mem_tester_pkg;

  localparam int          ADDR_W_DEF         = 13;
  localparam int          DATA_W_DEF         = 32;
  localparam logic [31:0] LFSR_MASK_DEFAULT  = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Galois step: shift right, fold the mask back in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] mask);
    return (x >> 1) ^ (x[0] ? mask : 32'h0);
  endfunction

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/medidor_desempenho_mem_tester_if.sv
// Avalon-MM command/response bundle between the tester and the memory s2 port.
interface medidor_desempenho_mem_tester_if
  import medidor_desempenho_mem_tester_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_chipselect;
  logic                m_write;
  logic                m_read;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_waitrequest;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_read, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_read, m_writedata,
    output m_readdata, m_waitrequest
  );
endinterface

// File: rtl/medidor_desempenho_lfsr32.sv
// 32-bit Galois LFSR; load has priority over step.
module medidor_desempenho_lfsr32
  import medidor_desempenho_mem_tester_pkg::*;
#(
  parameter logic [31:0] MASK = LFSR_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= '0;
    else if (load) value <= seed;
    else if (step) value <= lfsr_next(value, MASK);
  end

endmodule

// File: rtl/medidor_desempenho_mem_tester.sv
// Memory tester master: writes an LFSR pattern over a word range, reads it back
// pipelined (latency 1) and reports mismatches and busy-cycle count.
//
// state | meaning
// IDLE  | waiting for start; results held, done pulses here after DRAIN
// WR    | issuing write beats, one per accepted cycle
// RD    | issuing read beats; expected word registered per accepted beat
// DRAIN | no command; compares the data returned for the final read
module medidor_desempenho_mem_tester
  import medidor_desempenho_mem_tester_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          DATA_W    = DATA_W_DEF,
  parameter logic [31:0] LFSR_MASK = LFSR_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_found,
  output logic [31:0]       cycle_count,
  medidor_desempenho_mem_tester_if.master bus
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_r, beat_addr, exp_addr;
  logic [ADDR_W:0]   len_r, idx;
  logic [31:0]       seed_r, lfsr_seed, lfsr_val;
  logic [DATA_W-1:0] exp_data;
  logic              lfsr_load, lfsr_adv;
  logic              cmd_cs, cmd_wr, cmd_rd;
  logic              accept, last_beat, cmp_pending;

  medidor_desempenho_lfsr32 #(.MASK(LFSR_MASK)) u_lfsr (
    .clk   (clk),
    .rst   (reset),
    .load  (lfsr_load),
    .step  (lfsr_adv),
    .seed  (lfsr_seed),
    .value (lfsr_val)
  );

  // Address wraps naturally through the ADDR_W-bit sum.
  assign beat_addr = base_r + idx[ADDR_W-1:0];
  assign last_beat = (idx == len_r - ONE);
  assign accept    = cmd_cs && !bus.m_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_cs    = 1'b0;
    cmd_wr    = 1'b0;
    cmd_rd    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    lfsr_seed = seed_r;
    case (state)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          lfsr_seed = seed_fix(seed);
          state_nxt = (length == '0) ? DRAIN : WR;
        end
      end
      WR: begin
        cmd_cs = 1'b1;
        cmd_wr = 1'b1;
        if (!bus.m_waitrequest) begin
          if (last_beat) begin
            lfsr_load = 1'b1;
            state_nxt = RD;
          end else begin
            lfsr_adv = 1'b1;
          end
        end
      end
      RD: begin
        cmd_cs = 1'b1;
        cmd_rd = 1'b1;
        if (!bus.m_waitrequest) begin
          lfsr_adv = 1'b1;
          if (last_beat) state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy              = (state != IDLE);
  assign bus.m_chipselect  = cmd_cs;
  assign bus.m_write       = cmd_wr;
  assign bus.m_read        = cmd_rd;
  assign bus.m_address     = cmd_cs ? beat_addr : '0;
  assign bus.m_byteenable  = {(DATA_W/8){cmd_cs}};
  assign bus.m_writedata   = cmd_wr ? DATA_W'(lfsr_val) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_r         <= '0;
      len_r          <= '0;
      seed_r         <= '0;
      idx            <= '0;
      exp_data       <= '0;
      exp_addr       <= '0;
      cmp_pending    <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      err_found      <= 1'b0;
      cycle_count    <= '0;
      done           <= 1'b0;
    end else begin
      done        <= (state == DRAIN);
      cmp_pending <= accept && cmd_rd;
      if (busy && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
      if (state == IDLE && start) begin
        base_r         <= base_addr;
        len_r          <= length;
        seed_r         <= seed_fix(seed);
        idx            <= '0;
        error_count    <= '0;
        first_err_addr <= '0;
        err_found      <= 1'b0;
        cycle_count    <= '0;
      end
      if (accept) idx <= (cmd_wr && last_beat) ? '0 : idx + ONE;
      if (accept && cmd_rd) begin
        exp_data <= DATA_W'(lfsr_val);
        exp_addr <= beat_addr;
      end
      // Read data arrives exactly one cycle after the accepted read.
      if (cmp_pending && bus.m_readdata != exp_data) begin
        error_count <= error_count + ONE;
        if (!err_found) begin
          err_found      <= 1'b1;
          first_err_addr <= exp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_medidor_desempenho_mem_tester.sv
// Bench for the memory tester: RAM model with stalls/faults, beat-level reference queues.
module tb_medidor_desempenho_mem_tester;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, err_found;
  logic [AW:0]   error_count;
  logic [AW-1:0] first_err_addr;
  logic [31:0]   cycle_count;

  medidor_desempenho_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  medidor_desempenho_mem_tester dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .err_found      (err_found),
    .cycle_count    (cycle_count),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } beat_t;
  beat_t         wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [31:0]   mem [0:8191];

  int            stall_n = 0, stall_left = 0;
  bit            fault_en = 0;
  logic [AW-1:0] fault_addr = '0;
  bit            rd_pend = 0;
  logic [31:0]   rd_val = '0;
  bit            check_en = 0;
  int            exp_err = 0, exp_cycles = 0, done_cnt = 0;
  logic [AW-1:0] exp_first = '0;

  bit            prev_stall = 0, prev_wr = 0, prev_rd = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_step(logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h80200003;
    return y;
  endfunction

  // RAM slave: waitrequest decided at negedge for the coming edge, read data one cycle later.
  always @(negedge clk) begin
    bus.m_readdata = rd_pend ? rd_val : $urandom;
    rd_pend = 0;
    if (reset || !bus.m_chipselect) begin
      bus.m_waitrequest = 1'b0;
      stall_left = stall_n;
    end else if (stall_left > 0) begin
      bus.m_waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.m_waitrequest = 1'b0;
      stall_left = stall_n;
      if (bus.m_write) mem[bus.m_address] = bus.m_writedata;
      if (bus.m_read) begin
        rd_val = mem[bus.m_address];
        if (fault_en && bus.m_address == fault_addr) rd_val[0] = ~rd_val[0];
        rd_pend = 1;
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Beat-level compare against the expected write/read sequences.
  always @(negedge clk) begin
    #1;
    if (check_en && !reset) begin
      check("byteenable", bus.m_byteenable, bus.m_chipselect ? 4'hF : 4'h0);
      if (prev_stall) begin
        check("hold_addr", bus.m_address, prev_addr);
        check("hold_data", bus.m_writedata, prev_data);
        check("hold_cmd", {bus.m_chipselect, bus.m_write, bus.m_read}, {1'b1, prev_wr, prev_rd});
      end
      if (bus.m_chipselect) begin
        check("one_cmd", bus.m_write ^ bus.m_read, 1);
        if (bus.m_write) begin
          check("wr_expected", wr_q.size() > 0, 1);
          if (wr_q.size() > 0) begin
            check("wr_addr", bus.m_address, wr_q[0].a);
            check("wr_data", bus.m_writedata, wr_q[0].d);
            if (!bus.m_waitrequest) void'(wr_q.pop_front());
          end
        end else if (bus.m_read) begin
          check("rd_after_wr", wr_q.size(), 0);
          check("rd_expected", rd_q.size() > 0, 1);
          if (rd_q.size() > 0) begin
            check("rd_addr", bus.m_address, rd_q[0]);
            if (!bus.m_waitrequest) void'(rd_q.pop_front());
          end
        end
      end else begin
        check("idle_cmd", {bus.m_write, bus.m_read}, 0);
      end
      prev_stall = bus.m_chipselect && bus.m_waitrequest;
      prev_wr    = bus.m_write;
      prev_rd    = bus.m_read;
      prev_addr  = bus.m_address;
      prev_data  = bus.m_writedata;
    end else begin
      prev_stall = 0;
    end
  end

  // Build expected beats/results and raise start; caller is just past a negedge.
  task automatic prep(int b, int len, logic [31:0] s, int st, bit fe, int fa);
    logic [31:0] x;
    beat_t       bt;
    int          a;
    wr_q.delete();
    rd_q.delete();
    x = (s == 0) ? 32'd1 : s;
    for (int i = 0; i < len; i++) begin
      bt.a = AW'((b + i) % 8192);
      bt.d = x;
      wr_q.push_back(bt);
      x = ref_step(x);
    end
    exp_err = 0;
    exp_first = '0;
    for (int i = 0; i < len; i++) begin
      a = (b + i) % 8192;
      rd_q.push_back(AW'(a));
      if (fe && a == fa) begin
        if (exp_err == 0) exp_first = AW'(a);
        exp_err++;
      end
    end
    exp_cycles = 2 * len + 1 + st * 2 * len;
    stall_n    = st;
    fault_en   = fe;
    fault_addr = AW'(fa);
    done_cnt   = 0;
    base_addr  = AW'(b);
    length     = (AW+1)'(len);
    seed       = s;
    start      = 1'b1;
    check_en   = 1;
  endtask

  task automatic run(int b, int len, logic [31:0] s, int st, bit fe, int fa, int poke);
    int n;
    prep(b, len, s, st, fe, fa);
    @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW+1)'($urandom);
    seed      = $urandom;
    n = 1;
    check("busy_rise", busy, 1);
    while (!done && n < 2 * len * (st + 1) + 20) begin
      if (n == poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check("done_seen", done, 1);
    check("start_to_done", n, 2 * len + 2 + 2 * len * st);
    check("busy_at_done", busy, 0);
    check("error_count", error_count, exp_err);
    check("err_found", err_found, exp_err != 0);
    check("first_err_addr", first_err_addr, exp_first);
    check("cycle_count", cycle_count, exp_cycles);
    check("wr_left", wr_q.size(), 0);
    check("rd_left", rd_q.size(), 0);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("hold_errors", error_count, exp_err);
    check_en = 0;
  endtask

  logic [31:0] lit [4] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_readdata    = '0;
    bus.m_waitrequest = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_status", |{busy, done, error_count, first_err_addr, err_found, cycle_count}, 0);
    check("rst_bus", |{bus.m_address, bus.m_byteenable, bus.m_chipselect, bus.m_write,
                        bus.m_read, bus.m_writedata}, 0);
    reset = 1'b0;

    @(negedge clk); run(0, 4, 32'd1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) check("mem_pattern", mem[i], lit[i]);
    @(negedge clk); run(0, 4, 32'd1, 0, 1, 2, -1);
    @(negedge clk); run(8190, 4, 32'h1234_5678, 0, 0, 0, -1);
    @(negedge clk); run(100, 2, 32'hDEAD_BEEF, 2, 0, 0, -1);
    @(negedge clk); run(0, 0, 32'h55, 0, 0, 0, -1);
    foreach (mem[i]) mem[i] = '0;
    @(negedge clk); run(0, 4, 32'd0, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) check("mem_seed0", mem[i], lit[i]);
    @(negedge clk); run(40, 6, 32'h5EED, 0, 1, 43, 8);

    // Reset in the middle of the write phase, then a clean run right after release.
    @(negedge clk); prep(0, 8, 32'h1234, 0, 0, 0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_status", |{busy, done, error_count, first_err_addr, err_found, cycle_count}, 0);
    check("rst_async_bus", |{bus.m_address, bus.m_byteenable, bus.m_chipselect, bus.m_write,
                              bus.m_read, bus.m_writedata}, 0);
    check_en = 0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    rd_q.delete();
    reset = 1'b0;
    run(0, 8, 32'hACE1, 0, 0, 0, -1);

    for (int r = 0; r < 20; r++) begin
      int b, l, st, fa;
      bit fe;
      b  = $urandom_range(0, 8191);
      l  = $urandom_range(1, 24);
      st = $urandom_range(0, 2);
      fe = 1'($urandom_range(0, 1));
      fa = (b + $urandom_range(0, l - 1)) % 8192;
      @(negedge clk);
      run(b, l, $urandom, st, fe, fa, (r % 3 == 0) ? l + 2 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/medidor_desempenho_mem_tester.md
# medidor_desempenho_mem_tester

Avalon-MM master that exercises the 8192 x 32-bit program memory slave from the initiator side. A run writes a pseudo-random pattern over a word range, reads it back pipelined, and counts mismatches and bus cycles. Run results feed the performance-meter status registers. It sits beside the CPU data master on the memory's s2 port, and the interconnect arbitrates between them.

## Interface
Parameters:
- ADDR_W, 13, word-address width; memory depth is 2^ADDR_W.
- DATA_W, 32, data width; the byteenable width is DATA_W/8.
- LFSR_MASK, 32'h80200003, Galois feedback mask.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- base_addr  in  ADDR_W  first word address.
- length  in  ADDR_W+1  word count, 0..8192.
- seed  in  32  LFSR seed; 0 is replaced by 1.
- busy  out  1  high from start acceptance until the run ends.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- error_count  out  ADDR_W+1  number of mismatching words.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- err_found  out  1  set when first_err_addr is valid.
- cycle_count  out  32  busy cycles, saturating at 2^32-1.
- m_address  out  ADDR_W  word address.
- m_byteenable  out  DATA_W/8  all ones while chipselect is high, else 0.
- m_chipselect, m_write, m_read  out  1 each  Avalon command signals.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  read data; fixed read latency of 1.
- m_waitrequest  in  1  stall; tie to 0 for bare on-chip RAM.

## Operation
- States: IDLE, WR, RD, DRAIN.
- IDLE with start=1:
  - Clears error_count, err_found, first_err_addr and cycle_count.
  - Loads the LFSR with seed (1 if seed=0) and sets the index to 0.
  - Goes to WR, or to DRAIN if length=0.
- WR: drives chipselect=1, write=1, m_address=(base_addr+i) mod 2^ADDR_W and m_writedata=LFSR.
  - Each accepted beat (waitrequest=0) steps the LFSR and increments i.
  - After beat length-1 is accepted: reload the LFSR from seed, set i=0, go to RD.
- RD: drives chipselect=1, read=1, same address rule.
  - Each accepted beat registers the expected word (the LFSR value) and its address, then steps the LFSR.
  - After the last beat is accepted, go to DRAIN.
- Compare: in the cycle after each accepted read, m_readdata is compared with the registered expected word.
  - A mismatch increments error_count.
  - The first mismatch also sets err_found and first_err_addr.
- DRAIN: no command; completes the compare for the final read; then go to IDLE.
- LFSR step: next = (x>>1) ^ (x[0] ? LFSR_MASK : 0).
- start while busy is ignored. The inputs are sampled only at acceptance.
- Results hold until the next accepted start.

## Timing
- Reset (asynchronous) returns the block to IDLE. Every output is 0, including all m_* command signals, which are released immediately.
- Any run in progress is abandoned on reset. A start is accepted in the first cycle after reset deasserts.
- busy rises in the cycle after start is sampled and is high in WR, RD and DRAIN. cycle_count increments once per busy cycle.
- done pulses in the first IDLE cycle after DRAIN, with busy=0.
- With waitrequest at 0: cycle_count = 2*length + 1, and start-to-done is 2*length + 2 cycles.
- While waitrequest=1, address, data and command are held stable and nothing advances.
- Address wrap: 8191 is followed by 0.

## Structure
- Package medidor_desempenho_mem_tester_pkg holds:
  - the state enum;
  - LFSR_MASK;
  - ADDR_W/DATA_W defaults;
  - the LFSR step function.
- Sub-module medidor_desempenho_lfsr32 has inputs load, seed and step, and output value. There is one instance, reloaded at the WR to RD transition.

## Test plan
- seed=1, base=0, length=4, ideal RAM model:
  - writes 00000001, 80200003, C0300002, 60180001 to addresses 0..3;
  - error_count=0, err_found=0, cycle_count=9, exactly one done pulse.
- Same run with the model flipping bit 0 of the word at address 2 on read: error_count=1, err_found=1, first_err_addr=2.
- base=8190, length=4: addresses issued are 8190, 8191, 0, 1 in both phases; no errors.
- waitrequest high for 2 cycles before every beat, length=2: commands are held stable throughout; cycle_count=13, errors=0.
- Degenerate and ignored inputs:
  - length=0: no chipselect asserted, busy for 1 cycle, cycle_count=1, done pulses.
  - seed=0 behaves exactly like seed=1.
  - start pulsed during RD is ignored.
- Reset asserted during WR beat 3 of 8:
  - all outputs are 0 asynchronously;
  - a fresh start after release completes normally with cycle_count=17.
